// File: rtl/kp_pkg.sv
// Keypad entry shared types: key code constants and debounce FSM state encoding.
// Pure declarations, no latency; no backpressure.
package kp_pkg;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;
    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hD;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= KEY_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/kp_debounce.sv
// Key synchronizer + debounce FSM: one key_valid per press, DB_CYCLES+3 cycles after stable input.
// No backpressure; optional auto-repeat of digit keys while held when KP_AUTOREPEAT_EN is defined.
module kp_debounce #(
    parameter int DB_CYCLES     = 50000,
    parameter int REPEAT_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kphit,
    input  logic [3:0] num,
    output logic       key_valid,
    output logic [3:0] key_code
);
    import kp_pkg::*;

    localparam int DW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    if (DB_CYCLES < 2) begin : g_db_chk
        $error("kp_debounce: DB_CYCLES must be at least 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_rpt_chk
        $error("kp_debounce: REPEAT_CYCLES must be at least 2");
    end

    logic            hit_meta_q, hit_s_q;
    logic [3:0]      num_meta_q, num_s_q;
    kp_state_t       state_q, state_d;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [3:0]      cand_q, cand_d;
    logic            kv_q, kv_d;
    logic [3:0]      kc_q, kc_d;
    logic            db_last, rel_last;

`ifdef KP_AUTOREPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    logic [RW-1:0]   rpt_q, rpt_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_meta_q <= 1'b0;
            hit_s_q    <= 1'b0;
            num_meta_q <= KEY_NONE;
            num_s_q    <= KEY_NONE;
        end else begin
            hit_meta_q <= kphit;
            hit_s_q    <= hit_meta_q;
            num_meta_q <= num;
            num_s_q    <= num_meta_q;
        end
    end

    assign db_last  = (cnt_q == DW'(DB_CYCLES - 1));
    assign rel_last = db_last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        kv_d    = 1'b0;
        kc_d    = kc_q;
`ifdef KP_AUTOREPEAT_EN
        rpt_d   = rpt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (hit_s_q) begin
                    cand_d  = num_s_q;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!hit_s_q || (num_s_q != cand_q)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (db_last) begin
                    cnt_d   = '0;
                    kv_d    = 1'b1;
                    kc_d    = cand_q;
                    state_d = PRESSED;
`ifdef KP_AUTOREPEAT_EN
                    rpt_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            PRESSED: begin
                // num_s changes while held are deliberately ignored
                if (!hit_s_q) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
`ifdef KP_AUTOREPEAT_EN
                    rpt_d   = '0;
                end else if (rpt_q == RW'(REPEAT_CYCLES - 1)) begin
                    rpt_d = '0;
                    kv_d  = is_digit(cand_q);
                end else begin
                    rpt_d = rpt_q + RW'(1);
`endif
                end
            end
            RELEASE: begin
                if (hit_s_q) begin
                    cnt_d   = '0;
                    state_d = PRESSED;
`ifdef KP_AUTOREPEAT_EN
                    rpt_d   = '0;
`endif
                end else if (rel_last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= KEY_NONE;
            kv_q    <= 1'b0;
            kc_q    <= KEY_NONE;
`ifdef KP_AUTOREPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            kv_q    <= kv_d;
            kc_q    <= kc_d;
`ifdef KP_AUTOREPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    assign key_valid = kv_q;
    assign key_code  = kc_q;

endmodule

// File: rtl/kp_entry.sv
// Keypad entry: debounced key events feed an NDIG-digit BCD buffer with '*' clear and '#' commit.
// Buffer updates 1 cycle after key_valid; no backpressure. KP_AUTOREPEAT_EN enables digit auto-repeat.
module kp_entry #(
    parameter int DB_CYCLES     = 50000,
    parameter int NDIG          = 4,
    parameter int REPEAT_CYCLES = 25000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      kphit,
    input  logic [3:0]                num,
    output logic                      key_valid,
    output logic [3:0]                key_code,
    output logic [4*NDIG-1:0]         digits,
    output logic [$clog2(NDIG+1)-1:0] digit_cnt,
    output logic [4*NDIG-1:0]         entry_value,
    output logic                      entry_done
);
    import kp_pkg::*;

    localparam int CW = $clog2(NDIG + 1);

    if (NDIG < 2) begin : g_ndig_chk
        $error("kp_entry: NDIG must be at least 2");
    end

    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [4*NDIG-1:0] value_q, value_d;
    logic              done_q, done_d;

    kp_debounce #(
        .DB_CYCLES    (DB_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .kphit    (kphit),
        .num      (num),
        .key_valid(key_valid),
        .key_code (key_code)
    );

    always_comb begin
        digits_d = digits_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        done_d   = 1'b0;
        if (key_valid) begin
            case (key_code)
                KEY_STAR: begin
                    digits_d = '0;
                    cnt_d    = '0;
                end
                KEY_HASH: begin
                    // commit of an empty buffer is silently dropped
                    if (cnt_q != '0) begin
                        value_d  = digits_q;
                        done_d   = 1'b1;
                        digits_d = '0;
                        cnt_d    = '0;
                    end
                end
                KEY_A, KEY_B, KEY_C, KEY_D: begin
                    digits_d = digits_q;
                end
                default: begin
                    digits_d = {digits_q[4*NDIG-5:0], key_code};
                    if (cnt_q != CW'(NDIG)) cnt_d = cnt_q + CW'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_q <= '0;
            cnt_q    <= '0;
            value_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            digits_q <= digits_d;
            cnt_q    <= cnt_d;
            value_q  <= value_d;
            done_q   <= done_d;
        end
    end

    assign digits      = digits_q;
    assign digit_cnt   = cnt_q;
    assign entry_value = value_q;
    assign entry_done  = done_q;

endmodule

// File: tb/tb_kp_entry.sv
// Bench for kp_entry: directed scenarios plus randomized presses/glitches/bounces against a press-level model.
// Auto-repeat scenario is included when KP_AUTOREPEAT_EN is defined.
module tb_kp_entry;

    localparam int DB  = 4;
    localparam int ND  = 4;
    localparam int RPT = 10;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    kphit;
    logic [3:0]              num;
    logic                    key_valid;
    logic [3:0]              key_code;
    logic [4*ND-1:0]         digits;
    logic [$clog2(ND+1)-1:0] digit_cnt;
    logic [4*ND-1:0]         entry_value;
    logic                    entry_done;

    kp_entry #(.DB_CYCLES(DB), .NDIG(ND), .REPEAT_CYCLES(RPT)) dut (
        .clk        (clk),
        .reset      (reset),
        .kphit      (kphit),
        .num        (num),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .digits     (digits),
        .digit_cnt  (digit_cnt),
        .entry_value(entry_value),
        .entry_done (entry_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int ev_n   = 0;
    int done_n = 0;
    int ev_cyc[$];
    always @(negedge clk) begin
        if (key_valid) begin
            ev_n = ev_n + 1;
            ev_cyc.push_back(cyc);
        end
        if (entry_done) done_n = done_n + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Press-level reference: the entry buffer as a list of digits, oldest first.
    int              m_q[$];
    logic [4*ND-1:0] m_val    = '0;
    int              exp_ev   = 0;
    int              exp_done = 0;
    logic [3:0]      exp_code = 4'hF;

    function automatic logic [4*ND-1:0] m_digits();
        logic [4*ND-1:0] v;
        v = '0;
        foreach (m_q[i]) v = (v << 4) | (4*ND)'(m_q[i]);
        return v;
    endfunction

    task automatic model_key(input logic [3:0] c);
        exp_ev++;
        exp_code = c;
        if (c <= 4'd9) begin
            m_q.push_back(int'(c));
            if (m_q.size() > ND) void'(m_q.pop_front());
        end else if (c == 4'hE) begin
            m_q.delete();
        end else if (c == 4'hF && m_q.size() > 0) begin
            m_val = m_digits();
            exp_done++;
            m_q.delete();
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_val    = '0;
        exp_code = 4'hF;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic h, input logic [3:0] c);
        kphit = h;
        num   = h ? c : 4'hF;
    endtask

    task automatic press(input logic [3:0] c, input int hold, input int gap);
        drive(1'b1, c);
        tick(hold);
        drive(1'b0, 4'h0);
        tick(gap);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".events"}, ev_n, exp_ev);
        chk({tag, ".code"}, 32'(key_code), 32'(exp_code));
        chk({tag, ".digits"}, 32'(digits), 32'(m_digits()));
        chk({tag, ".cnt"}, 32'(digit_cnt), m_q.size());
        chk({tag, ".value"}, 32'(entry_value), 32'(m_val));
        chk({tag, ".done"}, done_n, exp_done);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".kv"}, 32'(key_valid), 0);
        chk({tag, ".code"}, 32'(key_code), 32'hF);
        chk({tag, ".digits"}, 32'(digits), 0);
        chk({tag, ".cnt"}, 32'(digit_cnt), 0);
        chk({tag, ".value"}, 32'(entry_value), 0);
        chk({tag, ".done"}, 32'(entry_done), 0);
    endtask

    initial begin
        int start;
        int k;
        logic [3:0] c;
        logic [3:0] seq[4];
        reset = 1'b1;
        drive(1'b0, 4'h0);
        tick(3);
        check_reset_vals("reset");
        reset = 1'b0;
        tick(3);

        // first-press latency: stable from the first sampling edge t, pulse seen in cycle t+DB+2
        start = cyc + 1;
        press(4'd5, 20, 12);
        model_key(4'd5);
        check_state("single5");
        if (ev_cyc.size() > 0) chk("single5.latency", ev_cyc[ev_cyc.size()-1], start + DB + 2);
        else chk("single5.latency", 0, start + DB + 2);
        chk("single5.digits_abs", 32'(digits), 32'h0005);

        seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd0; seq[3] = 4'hF;
        press(4'hE, 8, 10);
        model_key(4'hE);
        for (int i = 0; i < 4; i++) begin
            press(seq[i], 8, 10);
            model_key(seq[i]);
        end
        check_state("commit");
        chk("commit.value_abs", 32'(entry_value), 32'h0120);

        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'd7);
            tick(2);
            drive(1'b0, 4'h0);
            tick(2);
        end
        tick(8);
        check_state("toggle");
        start = cyc + 1;
        press(4'd4, 10, 10);
        model_key(4'd4);
        check_state("after_toggle");
        if (ev_cyc.size() > 0) chk("after_toggle.latency", ev_cyc[ev_cyc.size()-1], start + DB + 2);
        else chk("after_toggle.latency", 0, start + DB + 2);

        press(4'hE, 8, 10);
        model_key(4'hE);
        for (int i = 1; i <= 5; i++) begin
            press(4'(i), 8, 10);
            model_key(4'(i));
        end
        check_state("five");
        chk("five.digits_abs", 32'(digits), 32'h2345);
        press(4'hE, 8, 10);
        model_key(4'hE);
        check_state("star");

        press(4'hF, 8, 10);
        model_key(4'hF);
        check_state("hash_empty");

        // reset while key 9 is mid-debounce, key still held across reset release
        drive(1'b1, 4'd9);
        tick(4);
        reset = 1'b1;
        #2;
        model_reset();
        check_reset_vals("mid_reset");
        tick(2);
        reset = 1'b0;
        start = cyc + 1;
        tick(DB + 6);
        drive(1'b0, 4'h0);
        tick(10);
        model_key(4'd9);
        check_state("post_reset");
        if (ev_cyc.size() > 0) chk("post_reset.latency", ev_cyc[ev_cyc.size()-1], start + DB + 2);
        else chk("post_reset.latency", 0, start + DB + 2);

`ifdef KP_AUTOREPEAT_EN
        press(4'hE, 8, 10);
        model_key(4'hE);
        press(4'd3, 40, 12);
        // PRESSED spans (hold - DB) cycles; a repeat lands every RPT cycles inside it
        for (k = 0; RPT * k < 40 - DB; k++) model_key(4'd3);
        check_state("repeat");
        chk("repeat.digits_abs", 32'(digits), 32'h3333);
`endif

        for (int it = 0; it < 40; it++) begin
            c = 4'($urandom_range(0, 15));
            k = $urandom_range(0, 3);
            if (k <= 1) begin
                press(c, $urandom_range(DB + 2, 12), $urandom_range(DB + 4, DB + 8));
                model_key(c);
            end else if (k == 2) begin
                press(c, $urandom_range(1, DB), DB + 4);
            end else begin
                drive(1'b1, c);
                tick(DB + 3);
                drive(1'b0, 4'h0);
                tick($urandom_range(1, DB - 1));
                drive(1'b1, c);
                tick($urandom_range(1, 6));
                drive(1'b0, 4'h0);
                tick(DB + 6);
                model_key(c);
            end
            check_state($sformatf("rnd%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
